// File: rtl/uart_baud_pkg.sv
// Shared types and the bit-period table for the UART baud scheduler.
package uart_baud_pkg;

    localparam int RATE_W = 2;

    typedef logic [RATE_W-1:0] rate_t;

    // clk cycles per bit at 50 MHz: 9600, 19200, 57600, 115200 Bd
    localparam int BAUD_DIV_TABLE [4] = '{5208, 2604, 868, 434};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_t;

    function automatic int baud_div(rate_t rate);
        return BAUD_DIV_TABLE[rate];
    endfunction

endpackage

// File: rtl/uart_baud_sched_if.sv
// Rate-change handshake plus the TX/RX request/tick signals of the baud scheduler.
interface uart_baud_sched_if;
    import uart_baud_pkg::*;

    logic  cfg_valid;
    rate_t cfg_rate;
    logic  cfg_ready;
    rate_t cur_rate;
    logic  tx_req;
    logic  tx_tick;
    logic  rx_req;
    logic  rx_tick;
    logic  rx_mid;

    modport master (
        output cfg_valid, cfg_rate, tx_req, rx_req,
        input  cfg_ready, cur_rate, tx_tick, rx_tick, rx_mid
    );

    modport slave (
        input  cfg_valid, cfg_rate, tx_req, rx_req,
        output cfg_ready, cur_rate, tx_tick, rx_tick, rx_mid
    );

endinterface

// File: rtl/baud_phase_ctr.sv
// One baud channel: IDLE/RUN FSM, phase counter and registered tick/mid enables.
// The mid-bit comparator and register exist only when UART_BAUD_MID_EN is defined.
module baud_phase_ctr
    import uart_baud_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic             req,
    input  logic             mid_en,
    output logic             tick,
    output logic             mid,
    output logic             busy
);

    ch_state_t        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] last;
    logic             tick_d;

    assign last = div - DIV_W'(1);
    assign busy = (state_q == RUN);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // Dropping req suppresses whatever tick was due on this edge.
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    tick_d = (cnt_q == last);
                    cnt_d  = (cnt_q == last) ? '0 : cnt_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tick    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick    <= tick_d;
        end
    end

`ifdef UART_BAUD_MID_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mid <= 1'b0;
        end else begin
            mid <= (state_q == RUN) && req && mid_en && (cnt_q == (last >> 1));
        end
    end
`else
    logic unused_mid_en;
    assign unused_mid_en = mid_en;
    assign mid           = 1'b0;
`endif

endmodule

// File: rtl/uart_baud_sched.sv
// Baud-rate scheduler: one programmable bit period served to independent TX and RX
// phase counters; rate changes are accepted only while both channels are idle.
// rx_mid is generated only when UART_BAUD_MID_EN is defined.
module uart_baud_sched
    import uart_baud_pkg::*;
#(
    parameter int DIV_W        = 16,
    parameter int DEFAULT_RATE = 3
) (
    input logic              clk,
    input logic              rst,
    uart_baud_sched_if.slave bus
);

    localparam rate_t RESET_RATE = rate_t'(DEFAULT_RATE);

    logic [DIV_W-1:0] div_q;
    rate_t            rate_q;
    logic             tx_busy;
    logic             rx_busy;
    logic             tx_mid_unused;

    assign bus.cfg_ready = !tx_busy && !rx_busy;
    assign bus.cur_rate  = rate_q;

    // div_q only moves while both counters are idle, so no frame sees a rate change.
    always_ff @(posedge clk) begin
        if (rst) begin
            rate_q <= RESET_RATE;
            div_q  <= DIV_W'(baud_div(RESET_RATE));
        end else if (bus.cfg_valid && bus.cfg_ready) begin
            rate_q <= bus.cfg_rate;
            div_q  <= DIV_W'(baud_div(bus.cfg_rate));
        end
    end

    baud_phase_ctr #(.DIV_W(DIV_W)) u_tx_ctr (
        .clk    (clk),
        .rst    (rst),
        .div    (div_q),
        .req    (bus.tx_req),
        .mid_en (1'b0),
        .tick   (bus.tx_tick),
        .mid    (tx_mid_unused),
        .busy   (tx_busy)
    );

    baud_phase_ctr #(.DIV_W(DIV_W)) u_rx_ctr (
        .clk    (clk),
        .rst    (rst),
        .div    (div_q),
        .req    (bus.rx_req),
        .mid_en (1'b1),
        .tick   (bus.rx_tick),
        .mid    (bus.rx_mid),
        .busy   (rx_busy)
    );

endmodule

// File: tb/tb_uart_baud_sched.sv
// Self-checking bench for uart_baud_sched: directed scenarios plus random traffic,
// compared every cycle against a frame-phase arithmetic model.
module tb_uart_baud_sched;

    logic clk = 1'b0;
    logic rst;

    uart_baud_sched_if bus ();

    uart_baud_sched #(
        .DIV_W        (16),
        .DEFAULT_RATE (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

`ifdef UART_BAUD_MID_EN
    localparam bit MID_BUILT = 1'b1;
`else
    localparam bit MID_BUILT = 1'b0;
`endif

    typedef struct {
        bit act;
        int start;
        int div;
        bit tick;
        bit mid;
    } ch_model_t;

    int div_tab [4] = '{5208, 2604, 868, 434};

    int        checks = 0;
    int        errors = 0;
    int        n      = 0;
    int        m_rate = 3;
    bit        m_acc  = 1'b0;
    ch_model_t m_tx   = '{default: 0};
    ch_model_t m_rx   = '{default: 0};

    int scen_start;
    int tx_seen, rx_seen, mid_seen;
    int first_tx_off, first_rx_off, first_mid_off;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", tag, got, exp, n);
        end
    endtask

    // A running frame started at edge 'start'; ticks fall on whole multiples of the
    // bit period after it, mid pulses half a period (rounded down) plus one later.
    function automatic ch_model_t ch_next(ch_model_t c, bit req, int div_now, int edge_no);
        ch_model_t r = c;
        int        k;
        r.tick = 1'b0;
        r.mid  = 1'b0;
        if (!req) begin
            r.act = 1'b0;
        end else if (!c.act) begin
            r.act   = 1'b1;
            r.start = edge_no;
            r.div   = div_now;
        end else begin
            k      = (edge_no - c.start) % c.div;
            r.tick = (k == 0);
            r.mid  = (k == ((c.div - 1) / 2) + 1);
        end
        return r;
    endfunction

    task automatic clear_counts();
        tx_seen       = 0;
        rx_seen       = 0;
        mid_seen      = 0;
        first_tx_off  = -1;
        first_rx_off  = -1;
        first_mid_off = -1;
        scen_start    = n;
    endtask

    task automatic step();
        @(posedge clk);
        n++;
        if (rst) begin
            m_rate = 3;
            m_acc  = 1'b0;
            m_tx   = '{default: 0};
            m_rx   = '{default: 0};
        end else begin
            m_acc = bus.cfg_valid && !m_tx.act && !m_rx.act;
            if (m_acc) m_rate = int'(bus.cfg_rate);
            m_tx = ch_next(m_tx, bus.tx_req, div_tab[m_rate], n);
            m_rx = ch_next(m_rx, bus.rx_req, div_tab[m_rate], n);
        end
        #1;
        check("tx_tick", bus.tx_tick, m_tx.tick);
        check("rx_tick", bus.rx_tick, m_rx.tick);
        check("rx_mid", bus.rx_mid, MID_BUILT && m_rx.mid);
        check("cur_rate", bus.cur_rate, m_rate);
        check("cfg_ready", bus.cfg_ready, !m_tx.act && !m_rx.act);
        if (bus.tx_tick === 1'b1) begin
            tx_seen++;
            if (first_tx_off < 0) first_tx_off = n - scen_start;
        end
        if (bus.rx_tick === 1'b1) begin
            rx_seen++;
            if (first_rx_off < 0) first_rx_off = n - scen_start;
        end
        if (bus.rx_mid === 1'b1) begin
            mid_seen++;
            if (first_mid_off < 0) first_mid_off = n - scen_start;
        end
    endtask

    initial begin
        int lat;
        int pend;
        int stalls;

        rst           = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_rate  = 2'd0;
        bus.tx_req    = 1'b0;
        bus.rx_req    = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_cur_rate", bus.cur_rate, 3);
        check("rst_cfg_ready", bus.cfg_ready, 1);

        // RX frame at rate 3: mid at +217, ticks at +434 and +868
        bus.rx_req = 1'b1;
        step();
        clear_counts();
        repeat (900) step();
        bus.rx_req = 1'b0;
        step();
        check("s1_rx_ticks", rx_seen, 2);
        check("s1_first_rx", first_rx_off, 434);
        check("s1_tx_ticks", tx_seen, 0);
        check("s1_mid_count", mid_seen, MID_BUILT ? 2 : 0);
        check("s1_first_mid", first_mid_off, MID_BUILT ? 217 : -1);

        // Rate 0 accepted while idle, then a TX frame at 5208 cycles per bit
        bus.cfg_valid = 1'b1;
        bus.cfg_rate  = 2'd0;
        step();
        bus.cfg_valid = 1'b0;
        check("s2_cur_rate", bus.cur_rate, 0);
        bus.tx_req = 1'b1;
        step();
        clear_counts();
        repeat (10420) step();
        bus.tx_req = 1'b0;
        step();
        check("s2_tx_ticks", tx_seen, 2);
        check("s2_first_tx", first_tx_off, 5208);

        // Rate request while TX busy waits until the cycle after tx_req falls
        bus.tx_req = 1'b1;
        repeat (50) step();
        bus.cfg_valid = 1'b1;
        bus.cfg_rate  = 2'd3;
        repeat (20) step();
        check("s3_ready_busy", bus.cfg_ready, 0);
        check("s3_rate_held", bus.cur_rate, 0);
        bus.tx_req = 1'b0;
        lat = 0;
        while (lat < 10 && bus.cur_rate !== 2'd3) begin
            step();
            lat++;
        end
        bus.cfg_valid = 1'b0;
        check("s3_accept_lat", lat, 2);

        // TX at 0, RX at +100, rate 3
        bus.tx_req = 1'b1;
        step();
        clear_counts();
        repeat (99) step();
        bus.rx_req = 1'b1;
        repeat (901) step();
        bus.tx_req = 1'b0;
        bus.rx_req = 1'b0;
        step();
        check("s4_tx_ticks", tx_seen, 2);
        check("s4_rx_ticks", rx_seen, 2);
        check("s4_first_tx", first_tx_off, 434);
        check("s4_first_rx", first_rx_off, 534);

        // RX dropped while its counter holds 433: the due tick is suppressed
        bus.rx_req = 1'b1;
        step();
        clear_counts();
        repeat (433) step();
        bus.rx_req = 1'b0;
        repeat (3) step();
        check("s5_rx_ticks", rx_seen, 0);

        // Reset mid-frame after a rate change
        bus.cfg_valid = 1'b1;
        bus.cfg_rate  = 2'd1;
        step();
        bus.cfg_valid = 1'b0;
        check("s6_cur_rate", bus.cur_rate, 1);
        bus.tx_req = 1'b1;
        repeat (300) step();
        rst        = 1'b1;
        bus.tx_req = 1'b0;
        step();
        rst = 1'b0;
        check("s6_rst_rate", bus.cur_rate, 3);
        check("s6_rst_ready", bus.cfg_ready, 1);
        check("s6_rst_tick", bus.tx_tick, 0);
        step();
        check("s6_ready_next", bus.cfg_ready, 1);

        // Random traffic, rate requests and occasional resets
        stalls = 0;
        pend   = 0;
        for (int it = 0; it < 40; it++) begin
            if (!bus.cfg_valid && $urandom_range(0, 1) == 1) begin
                bus.cfg_rate  = ($urandom_range(0, 7) == 0) ? 2'd1 : 2'($urandom_range(2, 3));
                bus.cfg_valid = 1'b1;
                pend          = 0;
            end
            for (int c = 0; c < 1000; c++) begin
                if (bus.cfg_valid) begin
                    pend++;
                    if (bus.tx_req && $urandom_range(0, 49) == 0) bus.tx_req = 1'b0;
                    if (bus.rx_req && $urandom_range(0, 49) == 0) bus.rx_req = 1'b0;
                end else begin
                    if ($urandom_range(0, 699) == 0) bus.tx_req = !bus.tx_req;
                    if ($urandom_range(0, 699) == 0) bus.rx_req = !bus.rx_req;
                    if ($urandom_range(0, 1499) == 0) begin
                        bus.tx_req = 1'b1;
                        bus.rx_req = 1'b1;
                    end
                end
                rst = ($urandom_range(0, 4999) == 0);
                step();
                if (bus.cfg_valid && m_acc) begin
                    bus.cfg_valid = 1'b0;
                end else if (bus.cfg_valid && pend > 2000) begin
                    stalls++;
                    bus.cfg_valid = 1'b0;
                end
            end
        end
        rst           = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.tx_req    = 1'b0;
        bus.rx_req    = 1'b0;
        repeat (3) step();
        check("rand_cfg_stalls", stalls, 0);
        check("end_ready", bus.cfg_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
